sonar_scheduler: RTL and testbench
==================================

// Module: sonar_scheduler
// PURPOSE
//  Round-robin sequencer for up to NUM_SENSORS HC-SR04 ultrasonic rangers sharing one timing datapath.
//  Fires one sensor at a time to avoid acoustic crosstalk, measures its echo width in microseconds,
//  and publishes one tagged result per ping. Sits between the sensor pins and the intensity mapping
//  logic; runs from the 40 MHz system clock.
// PARAMETERS
//  CLK_PER_US   40     clk cycles per microsecond tick
//  NUM_SENSORS  4      sensor channels (1..8)
//  TRIG_US      20     trig high time per ping, us
//  RISE_TO_US   1000   max wait from trig fall to echo rise, us
//  ECHO_TO_US   40000  max echo high time before abort, us
//  GUARD_US     10000  quiet time after each ping before the next trig, us
// PORTS
//  clk           in   1               40 MHz system clock
//  reset         in   1               asynchronous, active-high reset
//  enable        in   1               1 = keep scheduling pings
//  sensor_mask   in   NUM_SENSORS     1 = channel participates in rotation
//  echo          in   NUM_SENSORS     raw echo pins, asynchronous
//  trig          out  NUM_SENSORS     trigger pins, at most one high at a time
//  result        out  12              echo width in us, saturated at 4095
//  result_id     out  $clog2(NUM_SENSORS)  channel that produced result
//  result_valid  out  1               one-clk strobe: result/result_id/result_timeout valid
//  result_timeout out 1               1 = no echo rise or echo overran ECHO_TO_US
//  busy          out  1               1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: state IDLE, trig=0, result=0, result_id=0, result_valid=0, result_timeout=0, busy=0,
//    prescaler/counters=0, current channel=NUM_SENSORS-1 (so first search starts at channel 0).
//  - echo: two-flop synchronizer per channel; all decisions use synchronized value; rise/fall = sync edge.
//  - Timebase: us_tick one-clk pulse every CLK_PER_US clks; prescaler free-runs from reset.
//  - Counters advance only on us_tick; us_cnt is 16 bits; cleared on every state entry.
//  - IDLE: if enable && |sensor_mask: pick next channel = first set mask bit strictly after current,
//    wrapping; latch it; go TRIG. Otherwise stay. Mask sampled only at selection time.
//  - TRIG: trig[ch]=1; after TRIG_US ticks, trig[ch]=0, go WAIT_RISE.
//  - WAIT_RISE: on echo rising edge (0->1; a level already high does not count) go MEASURE;
//    if us_cnt reaches RISE_TO_US first -> emit result=0, timeout=1, go GUARD.
//  - MEASURE: count ticks while echo high. On echo fall -> emit result=min(us_cnt,4095), timeout=0,
//    go GUARD. If us_cnt reaches ECHO_TO_US -> emit result=4095, timeout=1, go GUARD.
//  - GUARD: after GUARD_US ticks -> if enable && |sensor_mask select next channel and go TRIG
//    directly (no IDLE cycle); else go IDLE.
//  - Emit: result_valid high for exactly the clk following the terminating event; result, result_id,
//    result_timeout updated that same clk and held until next emit.
//  - Echo fall and timeout on same tick: fall wins (timeout=0).
//  - enable deasserted mid-ping: current ping completes, result emitted, GUARD runs, then IDLE.
//  - Mask bit of active channel cleared mid-ping: ping completes normally.
//  - Single-bit mask: same channel re-fired every cycle. Mask=0: IDLE, no trig.
//  - reset mid-operation: all outputs return to reset values immediately; trig dropped asynchronously.
//  - Latency: echo pin fall -> result_valid = 3 or 4 clk (sync + detect + register).
// STRUCTURE
//  - Package sonar_pkg: enum sched_state_t {IDLE, TRIG, WAIT_RISE, MEASURE, GUARD};
//    localparam RESULT_W=12, RESULT_MAX=12'd4095, US_CNT_W=16.
//  - Sub-module us_tick (param CLK_PER_US): prescaler producing the one-clk tick.
//  - Next-channel round-robin search as a function in this module; FSM + counters here.
// TESTING
//  1 Mask=4'b0001, echo rises 5 us after trig fall, high 1000 us -> trig[0] high 20 us,
//    result=1000 (+/-1), id=0, timeout=0, one-clk valid.
//  2 Mask=4'b1011, enable held -> trig order 0,1,3,0; never two trig bits high; GUARD gap >=10000 us.
//  3 Echo never rises -> valid after 1000 us in WAIT_RISE, result=0, timeout=1; next channel fires.
//  4 Echo stuck high from before trig, then held 50000 us -> no rise counted -> timeout via RISE_TO_US;
//    separately a fresh 45000 us echo -> result=4095, timeout=1 at 40000 us.
//  5 Echo width 5000 us -> result=4095, timeout=0 (saturation, not abort).
//  6 Reset asserted during MEASURE on channel 2 -> trig=0, valid=0, busy=0 at once; after release
//    with mask=4'b1111 first trig is channel 0.

Source files
------------

// File: rtl/sonar_pkg.sv
// Shared types and widths for the sonar ranging scheduler.
package sonar_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG      = 3'd1,
        WAIT_RISE = 3'd2,
        MEASURE   = 3'd3,
        GUARD     = 3'd4
    } sched_state_t;

    localparam int               RESULT_W   = 12;
    localparam logic [RESULT_W-1:0] RESULT_MAX = 12'd4095;
    localparam int               US_CNT_W   = 16;

endpackage

// File: rtl/sonar_scheduler_us_tick.sv
// Microsecond timebase: one-clk tick every CLK_PER_US clocks, free-running from reset.
module us_tick #(
    parameter int CLK_PER_US = 40
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
    localparam logic [PW-1:0] RELOAD = PW'(CLK_PER_US - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - PW'(1);
        end
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/sonar_scheduler.sv
// Round-robin HC-SR04 ping sequencer: fires one channel at a time and reports echo width in us.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  IDLE      | no ping in progress, waiting for enable and a non-empty mask
//  TRIG      | trig pin of the selected channel held high for TRIG_US
//  WAIT_RISE | waiting for a fresh echo rising edge, bounded by RISE_TO_US
//  MEASURE   | counting us while echo is high, bounded by ECHO_TO_US
//  GUARD     | acoustic quiet time before the next ping
module sonar_scheduler
    import sonar_pkg::*;
#(
    parameter int CLK_PER_US  = 40,
    parameter int NUM_SENSORS = 4,
    parameter int TRIG_US     = 20,
    parameter int RISE_TO_US  = 1000,
    parameter int ECHO_TO_US  = 40000,
    parameter int GUARD_US    = 10000,
    localparam int CH_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trig,
    output logic [RESULT_W-1:0]    result,
    output logic [CH_W-1:0]        result_id,
    output logic                   result_valid,
    output logic                   result_timeout,
    output logic                   busy
);

    localparam logic [US_CNT_W-1:0] TRIG_TC  = US_CNT_W'(TRIG_US);
    localparam logic [US_CNT_W-1:0] RISE_TC  = US_CNT_W'(RISE_TO_US);
    localparam logic [US_CNT_W-1:0] ECHO_TC  = US_CNT_W'(ECHO_TO_US);
    localparam logic [US_CNT_W-1:0] GUARD_TC = US_CNT_W'(GUARD_US);

    sched_state_t          state;
    logic [CH_W-1:0]       ch;
    logic [US_CNT_W-1:0]   us_cnt;
    logic                  tick;
    logic [NUM_SENSORS-1:0] echo_s1, echo_s2, echo_d;
    logic                  echo_rise, echo_fall;
    logic                  start_ok;
    logic [RESULT_W-1:0]   width_sat;

    // First set mask bit strictly after cur, wrapping; a lone bit at cur selects cur again.
    function automatic logic [CH_W-1:0] next_channel(input logic [CH_W-1:0] cur,
                                                     input logic [NUM_SENSORS-1:0] mask);
        logic [CH_W-1:0] pick;
        logic [CH_W-1:0] idx;
        pick = cur;
        for (int i = NUM_SENSORS; i >= 1; i--) begin
            idx = CH_W'((int'(cur) + i) % NUM_SENSORS);
            if (mask[idx]) pick = idx;
        end
        return pick;
    endfunction

    us_tick #(.CLK_PER_US(CLK_PER_US)) u_us_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
            echo_d  <= '0;
        end else begin
            echo_s1 <= echo;
            echo_s2 <= echo_s1;
            echo_d  <= echo_s2;
        end
    end

    assign echo_rise = echo_s2[ch] & ~echo_d[ch];
    assign echo_fall = ~echo_s2[ch] & echo_d[ch];
    assign start_ok  = enable & (|sensor_mask);
    assign width_sat = (|us_cnt[US_CNT_W-1:RESULT_W]) ? RESULT_MAX : us_cnt[RESULT_W-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            ch             <= CH_W'(NUM_SENSORS - 1);
            us_cnt         <= '0;
            result         <= '0;
            result_id      <= '0;
            result_valid   <= 1'b0;
            result_timeout <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            if (tick) us_cnt <= us_cnt + US_CNT_W'(1);
            case (state)
                IDLE: begin
                    us_cnt <= '0;
                    if (start_ok) begin
                        ch    <= next_channel(ch, sensor_mask);
                        state <= TRIG;
                    end
                end
                TRIG: begin
                    if (us_cnt == TRIG_TC) begin
                        us_cnt <= '0;
                        state  <= WAIT_RISE;
                    end
                end
                WAIT_RISE: begin
                    if (echo_rise) begin
                        us_cnt <= '0;
                        state  <= MEASURE;
                    end else if (us_cnt == RISE_TC) begin
                        result         <= '0;
                        result_id      <= ch;
                        result_timeout <= 1'b1;
                        result_valid   <= 1'b1;
                        us_cnt         <= '0;
                        state          <= GUARD;
                    end
                end
                MEASURE: begin
                    // Fall is checked first so a fall coinciding with the limit is a good reading.
                    if (echo_fall) begin
                        result         <= width_sat;
                        result_id      <= ch;
                        result_timeout <= 1'b0;
                        result_valid   <= 1'b1;
                        us_cnt         <= '0;
                        state          <= GUARD;
                    end else if (us_cnt == ECHO_TC) begin
                        result         <= RESULT_MAX;
                        result_id      <= ch;
                        result_timeout <= 1'b1;
                        result_valid   <= 1'b1;
                        us_cnt         <= '0;
                        state          <= GUARD;
                    end
                end
                GUARD: begin
                    if (us_cnt == GUARD_TC) begin
                        us_cnt <= '0;
                        if (start_ok) begin
                            ch    <= next_channel(ch, sensor_mask);
                            state <= TRIG;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    us_cnt <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Decoded from state so an async reset drops the pin without waiting for a clock.
    assign trig = (state == TRIG) ? (NUM_SENSORS'(1) << ch) : '0;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_sonar_scheduler.sv
// Directed bench for sonar_scheduler with shortened timing parameters.
module tb_sonar_scheduler;

    localparam int CPU   = 2;
    localparam int NS    = 4;
    localparam int TRIGU = 4;
    localparam int RISEU = 50;
    localparam int ECHOU = 5000;
    localparam int GRDU  = 30;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic [NS-1:0] sensor_mask = '0;
    logic [NS-1:0] echo = '0;
    logic [NS-1:0] trig;
    logic [11:0]   result;
    logic [1:0]    result_id;
    logic          result_valid;
    logic          result_timeout;
    logic          busy;

    sonar_scheduler #(
        .CLK_PER_US (CPU),
        .NUM_SENSORS(NS),
        .TRIG_US    (TRIGU),
        .RISE_TO_US (RISEU),
        .ECHO_TO_US (ECHOU),
        .GUARD_US   (GRDU)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sensor_mask   (sensor_mask),
        .echo          (echo),
        .trig          (trig),
        .result        (result),
        .result_id     (result_id),
        .result_valid  (result_valid),
        .result_timeout(result_timeout),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    int          cyc = 0;
    int          trig_rises = 0, valid_cnt = 0;
    int          last_trig_ch = -1, trig_rise_cyc = 0, trig_fall_cyc = 0, last_trig_len = 0;
    int          last_valid_cyc = 0, last_gap = 0, echo_rise_cyc = 0;
    logic [11:0] last_res = '0;
    logic [1:0]  last_id = '0;
    logic        last_to = 1'b0;
    logic [NS-1:0] prev_trig = '0;
    logic        prev_valid = 1'b0;
    logic        multi_trig = 1'b0, long_valid = 1'b0;

    task automatic check(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int in_range(input int v, input int lo, input int hi);
        return (v >= lo && v <= hi) ? 1 : 0;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_trig  <= trig;
        prev_valid <= result_valid;
        if ($countones(trig) > 1) multi_trig <= 1'b1;
        if (result_valid && prev_valid) long_valid <= 1'b1;
        if (trig != '0 && prev_trig == '0) begin
            trig_rises    <= trig_rises + 1;
            trig_rise_cyc <= cyc;
            last_gap      <= cyc - last_valid_cyc;
            for (int i = 0; i < NS; i++) if (trig[i]) last_trig_ch <= i;
        end
        if (trig == '0 && prev_trig != '0) begin
            trig_fall_cyc <= cyc;
            last_trig_len <= cyc - trig_rise_cyc;
        end
        if (result_valid) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
            last_res       <= result;
            last_id        <= result_id;
            last_to        <= result_timeout;
        end
    end

    task automatic do_reset(input logic [NS-1:0] mask, input logic [NS-1:0] echo_lvl);
        enable = 1'b0;
        sensor_mask = mask;
        echo = echo_lvl;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_trig(input int n0, input string tag);
        for (int i = 0; i < 2000 && trig_rises == n0; i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_trig_seen"}, int'(trig_rises != n0), 1);
    endtask

    task automatic wait_valid(input int v0, input string tag);
        for (int i = 0; i < 20000 && valid_cnt == v0; i++) begin
            @(posedge clk); #1;
        end
        check({tag, "_valid_seen"}, int'(valid_cnt != v0), 1);
    endtask

    task automatic ping(input int ch, input int delay_us, input int width_us,
                        input logic drop_en, input string tag);
        int n0, v0;
        n0 = trig_rises;
        v0 = valid_cnt;
        wait_trig(n0, tag);
        check({tag, "_ch"}, last_trig_ch, ch);
        if (drop_en) enable = 1'b0;
        for (int i = 0; i < 1000 && trig != '0; i++) begin
            @(posedge clk); #1;
        end
        if (width_us > 0) begin
            repeat (delay_us * CPU) @(posedge clk);
            #1 echo[ch] = 1'b1;
            echo_rise_cyc = cyc;
            fork
                begin
                    repeat (width_us * CPU) @(posedge clk);
                    #1 echo[ch] = 1'b0;
                end
                wait_valid(v0, tag);
            join
        end else begin
            wait_valid(v0, tag);
        end
    endtask

    initial begin
        int n0;
        do_reset(4'b0000, 4'b0000);
        @(negedge clk);
        check("rst_trig", int'(trig), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_valid", int'(result_valid), 0);
        check("rst_result", int'(result), 0);
        check("rst_id", int'(result_id), 0);
        check("rst_timeout", int'(result_timeout), 0);

        // mask empty: nothing fires
        enable = 1'b1;
        n0 = trig_rises;
        repeat (100) @(posedge clk);
        #1;
        check("mask0_busy", int'(busy), 0);
        check("mask0_no_trig", trig_rises - n0, 0);

        // single channel, 1000 us echo; enable dropped mid-ping
        do_reset(4'b0001, 4'b0000);
        enable = 1'b1;
        ping(0, 5, 1000, 1'b1, "t1");
        @(posedge clk); #1;
        check("t1_trig_len", in_range(last_trig_len, TRIGU*CPU - 2, TRIGU*CPU + 2), 1);
        check("t1_result", in_range(int'(last_res), 999, 1001), 1);
        check("t1_id", int'(last_id), 0);
        check("t1_timeout", int'(last_to), 0);
        n0 = trig_rises;
        repeat ((GRDU + 10) * CPU) @(posedge clk);
        #1;
        check("t1_idle_after", int'(busy), 0);
        check("t1_no_refire", trig_rises - n0, 0);

        // round robin over 4'b1011
        do_reset(4'b1011, 4'b0000);
        enable = 1'b1;
        ping(0, 2, 10, 1'b0, "t2a");
        check("t2a_result", in_range(int'(last_res), 9, 11), 1);
        ping(1, 2, 10, 1'b0, "t2b");
        check("t2b_gap", in_range(last_gap, GRDU*CPU, GRDU*CPU + 4), 1);
        check("t2b_id", int'(last_id), 1);
        ping(3, 2, 10, 1'b0, "t2c");
        check("t2c_id", int'(last_id), 3);
        ping(0, 2, 10, 1'b1, "t2d");
        check("t2d_gap", in_range(last_gap, GRDU*CPU, GRDU*CPU + 4), 1);

        // no echo: rise timeout, then next channel fires
        do_reset(4'b0011, 4'b0000);
        enable = 1'b1;
        ping(0, 0, 0, 1'b0, "t3");
        check("t3_result", int'(last_res), 0);
        check("t3_timeout", int'(last_to), 1);
        check("t3_id", int'(last_id), 0);
        check("t3_latency", in_range(last_valid_cyc - trig_fall_cyc, RISEU*CPU - 2, RISEU*CPU + 4), 1);
        ping(1, 2, 10, 1'b1, "t3b");
        check("t3b_timeout", int'(last_to), 0);

        // echo stuck high before trig: no rise counted
        do_reset(4'b0001, 4'b0001);
        enable = 1'b1;
        ping(0, 0, 0, 1'b1, "t4a");
        check("t4a_result", int'(last_res), 0);
        check("t4a_timeout", int'(last_to), 1);
        echo = '0;

        // echo longer than ECHO_TO_US: abort
        do_reset(4'b0001, 4'b0000);
        enable = 1'b1;
        ping(0, 3, 6000, 1'b1, "t4b");
        check("t4b_result", int'(last_res), 4095);
        check("t4b_timeout", int'(last_to), 1);
        check("t4b_latency", in_range(last_valid_cyc - echo_rise_cyc, ECHOU*CPU - 2, ECHOU*CPU + 8), 1);

        // width beyond 12 bits but under abort: saturate only
        do_reset(4'b0001, 4'b0000);
        enable = 1'b1;
        ping(0, 3, 4200, 1'b1, "t5");
        check("t5_result", int'(last_res), 4095);
        check("t5_timeout", int'(last_to), 0);

        // async reset during MEASURE on channel 2
        do_reset(4'b0100, 4'b0000);
        enable = 1'b1;
        n0 = trig_rises;
        wait_trig(n0, "t6");
        check("t6_ch", last_trig_ch, 2);
        for (int i = 0; i < 1000 && trig != '0; i++) begin
            @(posedge clk); #1;
        end
        repeat (2 * CPU) @(posedge clk);
        #1 echo[2] = 1'b1;
        repeat (200 * CPU) @(posedge clk);
        @(negedge clk);
        check("t6_busy_pre", int'(busy), 1);
        #1 reset = 1'b1;
        #1;
        check("t6_rst_trig", int'(trig), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_valid", int'(result_valid), 0);
        echo = '0;
        sensor_mask = 4'b1111;
        @(posedge clk);
        #1 reset = 1'b0;
        n0 = trig_rises;
        wait_trig(n0, "t6b");
        check("t6b_first_ch", last_trig_ch, 0);
        enable = 1'b0;

        check("one_trig_max", int'(multi_trig), 0);
        check("valid_one_clk", int'(long_valid), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
